// File: rtl/rand_pkg.sv
// -----------------------------------------------------------------------------
// rand_pkg
// Shared definitions for the xorshift32 stream checker:
//   - chk_state_e : checker FSM states (IDLE, RUN, DONE)
//   - default beat count, idle timeout and xorshift shift amounts
//   - xorshift32(): one xorshift32 step using the default shift amounts
// -----------------------------------------------------------------------------
package rand_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    localparam int NUM_OUT_DEF = 256;
    localparam int TIMEOUT_DEF = 1000;
    localparam int SH_A_DEF    = 13;
    localparam int SH_B_DEF    = 17;
    localparam int SH_C_DEF    = 5;

    // One xorshift32 step; all shifts are logical and overflow bits drop off.
    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] t;
        t = x;
        t = t ^ (t << SH_A_DEF);
        t = t ^ (t >> SH_B_DEF);
        t = t ^ (t << SH_C_DEF);
        return t;
    endfunction

endpackage

// File: rtl/xorshift32_step.sv
// -----------------------------------------------------------------------------
// xorshift32_step
// Purely combinational single step of the xorshift32 generator.
// Ports:
//   x_i : current 32-bit state
//   x_o : next 32-bit state (x ^= x<<SH_A; x ^= x>>SH_B; x ^= x<<SH_C)
// -----------------------------------------------------------------------------
module xorshift32_step
    import rand_pkg::*;
#(
    parameter int SH_A = SH_A_DEF,
    parameter int SH_B = SH_B_DEF,
    parameter int SH_C = SH_C_DEF
) (
    input  logic [31:0] x_i,
    output logic [31:0] x_o
);

    logic [31:0] t1_s;
    logic [31:0] t2_s;

    // Three xor-shift stages in sequence.
    always_comb begin
        t1_s = x_i ^ (x_i << SH_A);
        t2_s = t1_s ^ (t1_s >> SH_B);
        x_o  = t2_s ^ (t2_s << SH_C);
    end

endmodule

// File: rtl/rand_stream_checker.sv
// -----------------------------------------------------------------------------
// rand_stream_checker
// Consumes the xorshift32 random stream, regenerates the expected sequence
// from the captured seed and compares every valid beat against it.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   seed_valid/seed : one-cycle seed strobe and seed value
//   out_valid       : generator beat valid
//   rand_num        : generator beat value
//   busy            : high while a run is in progress
//   done            : one-cycle pulse at end of a run
//   pass            : run result, held until the next accepted seed
//   err_cnt         : mismatching beats (saturates at 511)
//   first_err_idx   : beat index of the first mismatch
//   first_err_exp   : expected value at the first mismatch
//   timeout         : run aborted because beats stopped arriving
//   proto_err       : protocol violation seen (sticky per run)
// -----------------------------------------------------------------------------
module rand_stream_checker
    import rand_pkg::*;
#(
    parameter int NUM_OUT = NUM_OUT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int SH_A    = SH_A_DEF,
    parameter int SH_B    = SH_B_DEF,
    parameter int SH_C    = SH_C_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_valid,
    input  logic [31:0] seed,
    input  logic        out_valid,
    input  logic [31:0] rand_num,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [8:0]  err_cnt,
    output logic [7:0]  first_err_idx,
    output logic [31:0] first_err_exp,
    output logic        timeout,
    output logic        proto_err
);

    localparam int              IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [7:0]      LAST_IDX = 8'(NUM_OUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT - 1);

    chk_state_e        state_q, state_d;
    logic [31:0]       x_q, x_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [8:0]        err_cnt_q, err_cnt_d;
    logic [7:0]        first_idx_q, first_idx_d;
    logic [31:0]       first_exp_q, first_exp_d;
    logic              timeout_q, timeout_d;
    logic              proto_q, proto_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [31:0]       step_in_s;
    logic [31:0]       step_out_s;

    // The single step core either seeds the sequence (IDLE) or advances it.
    always_comb begin
        if (state_q == IDLE) begin
            step_in_s = seed;
        end else begin
            step_in_s = x_q;
        end
    end

    xorshift32_step #(
        .SH_A (SH_A),
        .SH_B (SH_B),
        .SH_C (SH_C)
    ) u_step (
        .x_i (step_in_s),
        .x_o (step_out_s)
    );

    // Next-state and result logic for the checker FSM.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        err_cnt_d   = err_cnt_q;
        first_idx_d = first_idx_q;
        first_exp_d = first_exp_q;
        timeout_d   = timeout_q;
        proto_d     = proto_q;
        pass_d      = pass_q;

        case (state_q)
            IDLE: begin
                if (seed_valid) begin
                    // Seed load wins over a coincident stray beat.
                    x_d         = step_out_s;
                    cnt_d       = 8'd0;
                    idle_d      = '0;
                    err_cnt_d   = 9'd0;
                    first_idx_d = 8'd0;
                    first_exp_d = 32'd0;
                    timeout_d   = 1'b0;
                    proto_d     = 1'b0;
                    pass_d      = 1'b0;
                    state_d     = RUN;
                end else if (out_valid) begin
                    proto_d = 1'b1;
                end else begin
                    proto_d = proto_q;
                end
            end
            RUN: begin
                if (seed_valid) begin
                    proto_d = 1'b1;
                end else begin
                    proto_d = proto_q;
                end
                if (out_valid) begin
                    if (rand_num != x_q) begin
                        if (err_cnt_q != 9'h1FF) begin
                            err_cnt_d = err_cnt_q + 9'd1;
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                        // First mismatch of the run is the one with an empty count.
                        if (err_cnt_q == 9'd0) begin
                            first_idx_d = cnt_q;
                            first_exp_d = x_q;
                        end else begin
                            first_idx_d = first_idx_q;
                        end
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    x_d    = step_out_s;
                    cnt_d  = cnt_q + 8'd1;
                    idle_d = '0;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                    // This idle cycle is the TIMEOUT-th since the last beat.
                    if (idle_q == IDLE_LIM) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                pass_d  = (err_cnt_q == 9'd0) && !timeout_q && !proto_q;
                state_d = IDLE;
                if (out_valid || seed_valid) begin
                    proto_d = 1'b1;
                end else begin
                    proto_d = proto_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= 32'd0;
            cnt_q       <= 8'd0;
            idle_q      <= '0;
            err_cnt_q   <= 9'd0;
            first_idx_q <= 8'd0;
            first_exp_q <= 32'd0;
            timeout_q   <= 1'b0;
            proto_q     <= 1'b0;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            err_cnt_q   <= err_cnt_d;
            first_idx_q <= first_idx_d;
            first_exp_q <= first_exp_d;
            timeout_q   <= timeout_d;
            proto_q     <= proto_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_idx_q;
    assign first_err_exp = first_exp_q;
    assign timeout       = timeout_q;
    assign proto_err     = proto_q;

endmodule

// File: tb/tb_rand_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_rand_stream_checker
// Self-checking bench for rand_stream_checker. Expected beats come from an
// arithmetic model of xorshift32 (shifts written as multiply/divide by powers
// of two); expected results are derived from what each scenario injects.
// -----------------------------------------------------------------------------
module tb_rand_stream_checker;

    localparam int NUM_OUT = 256;
    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_valid;
    logic [31:0] seed;
    logic        out_valid;
    logic [31:0] rand_num;
    logic        busy;
    logic        done;
    logic        pass;
    logic [8:0]  err_cnt;
    logic [7:0]  first_err_idx;
    logic [31:0] first_err_exp;
    logic        timeout;
    logic        proto_err;

    int          err_count   = 0;
    int          check_count = 0;
    int          done_seen   = 0;
    logic [31:0] exp_seq [NUM_OUT];

    rand_stream_checker dut (
        .clk           (clk),
        .rst           (rst),
        .seed_valid    (seed_valid),
        .seed          (seed),
        .out_valid     (out_valid),
        .rand_num      (rand_num),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .first_err_exp (first_err_exp),
        .timeout       (timeout),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    // Count done pulses as seen between clock edges.
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        check_count++;
        if (got !== want) begin
            err_count++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y * 32'd8192);     // << 13
        y = y ^ (y / 32'd131072);   // >> 17
        y = y ^ (y * 32'd32);       // << 5
        return y;
    endfunction

    task automatic make_seq(input logic [31:0] s);
        logic [31:0] x;
        x = s;
        for (int k = 0; k < NUM_OUT; k++) begin
            x = model_step(x);
            exp_seq[k] = x;
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_busy"},    32'(busy),          32'd0);
        check_eq({pfx, "_done"},    32'(done),          32'd0);
        check_eq({pfx, "_pass"},    32'(pass),          32'd0);
        check_eq({pfx, "_errcnt"},  32'(err_cnt),       32'd0);
        check_eq({pfx, "_idx"},     32'(first_err_idx), 32'd0);
        check_eq({pfx, "_exp"},     first_err_exp,      32'd0);
        check_eq({pfx, "_timeout"}, 32'(timeout),       32'd0);
        check_eq({pfx, "_proto"},   32'(proto_err),     32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_seed(input logic [31:0] s);
        seed_valid = 1'b1;
        seed       = s;
        @(negedge clk);
        seed_valid = 1'b0;
    endtask

    task automatic stray_beat(input logic [31:0] v);
        out_valid = 1'b1;
        rand_num  = v;
        @(negedge clk);
        out_valid = 1'b0;
    endtask

    // Plays nbeats beats of exp_seq; bad_a flips bit 0, bad_b flips bit 31,
    // seed_at raises a stray seed with that beat, rst_at resets on that beat.
    task automatic play(input int nbeats, input int maxgap, input int bad_a,
                        input int bad_b, input int seed_at, input int rst_at);
        int gap;
        for (int k = 0; k < nbeats; k++) begin
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (gap) @(negedge clk);
            rand_num = exp_seq[k];
            if (k == bad_a) rand_num = rand_num ^ 32'h0000_0001;
            if (k == bad_b) rand_num = rand_num ^ 32'h8000_0000;
            out_valid = 1'b1;
            if (k == seed_at) begin
                seed_valid = 1'b1;
                seed       = ~seed;
            end
            if (k == rst_at) rst = 1'b1;
            @(negedge clk);
            out_valid  = 1'b0;
            seed_valid = 1'b0;
            if (k == rst_at) begin
                rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        int          d0;
        int          n;
        logic [31:0] s;

        rst = 1'b1; seed_valid = 1'b0; out_valid = 1'b0; seed = 32'd0; rand_num = 32'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Clean back-to-back run from seed 1.
        make_seq(32'h0000_0001);
        send_seed(32'h0000_0001);
        check_eq("t1_busy", 32'(busy), 32'd1);
        d0 = done_seen;
        play(NUM_OUT, 0, -1, -1, -1, -1);
        check_eq("t1_done", 32'(done), 32'd1);
        @(negedge clk);
        check_eq("t1_done_cnt", 32'(done_seen - d0), 32'd1);
        check_eq("t1_pass",     32'(pass),    32'd1);
        check_eq("t1_errcnt",   32'(err_cnt), 32'd0);
        check_eq("t1_busy_end", 32'(busy),    32'd0);
        // Beat after the run: flagged, pass kept.
        stray_beat(32'h1234_5678);
        check_eq("t1_late_proto", 32'(proto_err), 32'd1);
        check_eq("t1_late_pass",  32'(pass),      32'd1);

        // Two corrupted beats.
        send_seed(32'h0000_0001);
        check_eq("t2_proto_clr", 32'(proto_err), 32'd0);
        play(NUM_OUT, 0, 10, 200, -1, -1);
        check_eq("t2_done", 32'(done), 32'd1);
        @(negedge clk);
        check_eq("t2_errcnt", 32'(err_cnt),       32'd2);
        check_eq("t2_idx",    32'(first_err_idx), 32'd10);
        check_eq("t2_exp",    first_err_exp,      exp_seq[10]);
        check_eq("t2_pass",   32'(pass),          32'd0);

        // Gapped clean run from a random seed.
        s = $urandom;
        make_seq(s);
        send_seed(s);
        play(NUM_OUT, 50, -1, -1, -1, -1);
        check_eq("t3_done", 32'(done), 32'd1);
        @(negedge clk);
        check_eq("t3_pass",   32'(pass),    32'd1);
        check_eq("t3_errcnt", 32'(err_cnt), 32'd0);

        // Stream stops after 100 beats: timeout after exactly TIMEOUT idle cycles.
        s = $urandom;
        make_seq(s);
        send_seed(s);
        play(100, 50, -1, -1, -1, -1);
        n = 0;
        while (timeout !== 1'b1 && n < TIMEOUT + 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("t3_to_cycles", 32'(n), 32'(TIMEOUT));
        check_eq("t3_to_done",   32'(done), 32'd1);
        @(negedge clk);
        check_eq("t3_to_flag", 32'(timeout), 32'd1);
        check_eq("t3_to_pass", 32'(pass),    32'd0);
        check_eq("t3_to_busy", 32'(busy),    32'd0);

        // Beat in IDLE before any seed, then a clean run clears it.
        do_reset();
        check_all_zero("t4_rst");
        stray_beat(32'hDEAD_BEEF);
        check_eq("t4_proto", 32'(proto_err), 32'd1);
        check_eq("t4_busy",  32'(busy),      32'd0);
        s = $urandom;
        make_seq(s);
        send_seed(s);
        check_eq("t4_proto_clr", 32'(proto_err), 32'd0);
        play(NUM_OUT, 3, -1, -1, -1, -1);
        @(negedge clk);
        check_eq("t4_pass", 32'(pass), 32'd1);

        // Stray seed at beat 50: sequence continues, run fails on protocol.
        s = $urandom;
        make_seq(s);
        send_seed(s);
        d0 = done_seen;
        play(NUM_OUT, 2, -1, -1, 50, -1);
        @(negedge clk);
        check_eq("t5_done_cnt", 32'(done_seen - d0), 32'd1);
        check_eq("t5_proto",    32'(proto_err), 32'd1);
        check_eq("t5_errcnt",   32'(err_cnt),   32'd0);
        check_eq("t5_pass",     32'(pass),      32'd0);

        // Reset at beat 128: everything clears, no done pulse.
        s = $urandom;
        make_seq(s);
        send_seed(s);
        d0 = done_seen;
        play(NUM_OUT, 0, 5, -1, -1, 128);
        check_all_zero("t6_rst");
        repeat (2) @(negedge clk);
        check_eq("t6_no_done", 32'(done_seen - d0), 32'd0);
        s = $urandom;
        make_seq(s);
        send_seed(s);
        play(NUM_OUT, 1, -1, -1, -1, -1);
        check_eq("t6_done", 32'(done), 32'd1);
        @(negedge clk);
        check_eq("t6_pass",   32'(pass),    32'd1);
        check_eq("t6_errcnt", 32'(err_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule

// File: doc/rand_stream_checker.md
Name: rand_stream_checker

Overview:
- Receive-side consumer of the random-number stream from the seed-driven xorshift generator.
- Captures the seed on a one-beat handshake and regenerates the expected xorshift32 sequence internally.
- Compares every valid output beat against the expected value, counts mismatches, and reports pass/fail with first-error detail.
- Used as an on-chip self-check and as a reusable bench monitor. Single clock domain, placed after the generator's output synchroniser.

Parameters:
- NUM_OUT, 256: beats expected per seed.
- TIMEOUT, 1000: idle cycles allowed between beats while in RUN before the run is aborted.
- SH_A, 13: first left-shift amount.
- SH_B, 17: right-shift amount.
- SH_C, 5: second left-shift amount.

Ports:
- clk, in, 1: single clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- seed_valid, in, 1: one-cycle seed strobe.
- seed, in, 32: seed value, sampled when seed_valid=1.
- out_valid, in, 1: generator output beat valid.
- rand_num, in, 32: generator output value.
- busy, out, 1: high while in RUN.
- done, out, 1: one-cycle pulse at end of run.
- pass, out, 1: result flag, held until the next accepted seed.
- err_cnt, out, 9: number of mismatching beats, saturates at 511.
- first_err_idx, out, 8: beat index of the first mismatch.
- first_err_exp, out, 32: expected value at the first mismatch.
- timeout, out, 1: run aborted by inactivity.
- proto_err, out, 1: protocol violation seen (sticky per run).

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: all outputs 0, FSM in IDLE, internal state register 0, beat counter 0, idle counter 0.
- Step function: x ^= x<<SH_A; x ^= x>>SH_B; x ^= x<<SH_C. All shifts logical, 32-bit, overflow bits discarded.
- Expected beat k (k = 0..NUM_OUT-1) is step applied k+1 times to the seed. Seed 0 gives an all-zero sequence and is checked normally.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - seed_valid=1: load state <= step(seed); clear err_cnt, first_err_*, timeout, proto_err, pass; beat counter <= 0; go to RUN next cycle.
  - out_valid=1 with no seed_valid: proto_err <= 1; no state change.
- RUN (busy=1):
  - Each out_valid beat: compare rand_num with state.
  - On mismatch: err_cnt++ (saturating). If it is the first mismatch, latch first_err_idx <= counter and first_err_exp <= state.
  - Then state <= step(state), counter++, idle counter <= 0.
  - Cycles without a beat: idle counter++.
  - idle counter reaches TIMEOUT: timeout <= 1, go to DONE.
  - seed_valid in RUN: ignored for loading; proto_err <= 1.
  - Beat with counter = NUM_OUT-1: after the compare, go to DONE.
  - Beats may be back-to-back or gapped; zero latency between acceptance and compare.
- DONE: lasts one cycle.
  - done=1.
  - pass <= (err_cnt==0 including the last beat) && !timeout && !proto_err.
  - Return to IDLE.
- Results (pass, err_cnt, first_err_*, timeout, proto_err) hold in IDLE until the next accepted seed_valid. A beat arriving after DONE sets proto_err (pass is not revised).
- seed_valid and out_valid in the same IDLE cycle: seed is accepted, the beat is flagged proto_err, and that beat is not compared. proto_err is then cleared by the seed load (seed load has priority) — the bench must not rely on this case.
- rst mid-run: immediate return to reset values next cycle; no done pulse.
- err_cnt width covers NUM_OUT up to 511; beyond that it saturates.

Decomposition:
- Package rand_pkg:
  - state enum {IDLE, RUN, DONE};
  - default NUM_OUT and shift constants;
  - function xorshift32(x).
- Sub-module xorshift32_step: combinational one-step core, 32-bit in/out, shift parameters. Instantiated once on the state register path. The seed-load mux selects seed vs state at its input.

Test Plan:
- Reset, then seed=0x00000001 and 256 correct beats (first beat 0x00042021) -> done pulse after the last beat, pass=1, err_cnt=0.
- Same stream with beat 10 XOR 0x1 and beat 200 corrupted -> err_cnt=2, first_err_idx=10, first_err_exp = correct beat-10 value, pass=0.
- Correct stream with random 0–50 cycle gaps between beats -> pass=1. Stop after 100 beats -> timeout=1 exactly TIMEOUT idle cycles after beat 99, done pulse, pass=0.
- Beat in IDLE before any seed -> proto_err=1. Next seed clears it; a clean run -> pass=1.
- seed_valid asserted at beat 50 -> proto_err=1, expected sequence unchanged, pass=0 at end.
- rst asserted at beat 128 -> all outputs 0 next cycle, no done pulse. A new seed afterwards runs a clean 256-beat pass.
